// File: rtl/sd_spi_pkg.sv
// SD SPI responder shared definitions.
// Command indices, R1 layout, OCR voltage window and framing states.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;

  localparam logic [29:0] OCR_VOLT = 30'h00FF8000;

  typedef enum logic [1:0] {
    ST_RX_WAIT,
    ST_CMD,
    ST_NCR,
    ST_RESP
  } state_e;

  function automatic logic [7:0] r1_f(
    input logic illegal,
    input logic idle
  );
    logic [7:0] r;
    r = 8'h00;
    r[R1_ILLEGAL] = illegal;
    r[R1_IDLE] = idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_spi_byte_if.sv
// SPI mode-0 byte interface: input synchronisers, sclk edge detect,
// rx/tx shifters and the byte_done strobe.
module sd_spi_byte_if (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte_i,
  output logic       spi_miso,
  output logic       cs_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o
);

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic       rise, fall, cs_fall, cs_s, mosi_s;

  logic [2:0] bit_q;
  logic [7:0] rx_q, rx_byte_q, tx_q;
  logic       done_q, miso_q, load_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[1:0], spi_cs};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign cs_s    = cs_q[1];
  assign mosi_s  = mosi_q[1];
  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign fall    = ~sclk_q[1] & sclk_q[2];
  assign cs_fall = cs_q[2] & ~cs_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_q     <= 3'd0;
      rx_q      <= 8'h00;
      rx_byte_q <= 8'h00;
      done_q    <= 1'b0;
      tx_q      <= 8'hFF;
      miso_q    <= 1'b1;
      load_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cs_s) begin
        bit_q  <= 3'd0;
        tx_q   <= 8'hFF;
        miso_q <= 1'b1;
        load_q <= 1'b0;
      end else if (cs_fall) begin
        miso_q <= tx_byte_i[7];
        tx_q   <= {tx_byte_i[6:0], 1'b1};
        load_q <= 1'b0;
      end else if (rise) begin
        rx_q  <= {rx_q[6:0], mosi_s};
        bit_q <= bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          done_q    <= 1'b1;
          rx_byte_q <= {rx_q[6:0], mosi_s};
          load_q    <= 1'b1;
        end
      end else if (fall) begin
        // first fall after a byte boundary starts the next tx byte
        if (load_q) begin
          miso_q <= tx_byte_i[7];
          tx_q   <= {tx_byte_i[6:0], 1'b1};
          load_q <= 1'b0;
        end else begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b1};
        end
      end
    end
  end

  assign spi_miso    = miso_q;
  assign cs_o        = cs_s;
  assign byte_done_o = done_q;
  assign rx_byte_o   = rx_byte_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: frames host commands, tracks init state
// and answers with R1/R3/R7.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter bit SD_V2    = 1'b1,
  parameter bit SDHC     = 1'b1,
  parameter int BUSY_CNT = 2,
  parameter int NCR      = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  state_e      state_q, state_d;
  logic        cs_s, done;
  logic [7:0]  rx_byte, tx_byte;
  logic [2:0]  cnt_q, len_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [39:0] resp_q;
  logic        in_idle_q, app_q;
  logic [7:0]  acmd_q;
  logic        ncr_last, resp_last;

  logic [39:0] dec_resp;
  logic [2:0]  dec_len;
  logic        idle_d, app_d;
  logic [7:0]  acmd_d;

  logic        cmd_valid_q, ready_q;
  logic [5:0]  cmd_index_q;
  logic [31:0] cmd_arg_q;

  sd_spi_byte_if u_byte_if (
    .clock       (clock),
    .reset_n     (reset_n),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .tx_byte_i   (tx_byte),
    .spi_miso    (spi_miso),
    .cs_o        (cs_s),
    .byte_done_o (done),
    .rx_byte_o   (rx_byte)
  );

  assign ncr_last  = (cnt_q == 3'(NCR - 1));
  assign resp_last = (cnt_q == len_q - 3'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RX_WAIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = ST_RX_WAIT;
    end else if (done) begin
      unique case (state_q)
        ST_RX_WAIT: if (rx_byte[7:6] == 2'b01) state_d = ST_CMD;
        ST_CMD:     if (cnt_q == 3'd5) state_d = ST_NCR;
        ST_NCR:     if (ncr_last) state_d = ST_RESP;
        ST_RESP:    if (resp_last) state_d = ST_RX_WAIT;
        default:    state_d = ST_RX_WAIT;
      endcase
    end
  end

  always_comb begin
    tx_byte = (state_q == ST_RESP) ? resp_q[39:32] : 8'hFF;
  end

  // decode sees the card state as it was before this command
  always_comb begin
    dec_resp = {r1_f(1'b1, in_idle_q), 32'hFFFF_FFFF};
    dec_len  = 3'd1;
    idle_d   = in_idle_q;
    app_d    = 1'b0;
    acmd_d   = acmd_q;
    unique case (1'b1)
      (idx_q == CMD0): begin
        idle_d = 1'b1;
        acmd_d = 8'd0;
        dec_resp[39:32] = 8'h01;
      end
      (idx_q == CMD8 && SD_V2): begin
        dec_resp = {r1_f(1'b0, in_idle_q), 16'h0000,
                    4'h0, arg_q[11:8], arg_q[7:0]};
        dec_len = 3'd5;
      end
      (idx_q == CMD55): begin
        app_d = 1'b1;
        dec_resp[39:32] = r1_f(1'b0, in_idle_q);
      end
      (idx_q == CMD41 && app_q): begin
        if (acmd_q < 8'(BUSY_CNT)) begin
          acmd_d = acmd_q + 8'd1;
          dec_resp[39:32] = 8'h01;
        end else begin
          idle_d = 1'b0;
          dec_resp[39:32] = 8'h00;
        end
      end
      (idx_q == CMD58): begin
        dec_resp = {r1_f(1'b0, in_idle_q), ~in_idle_q,
                    SDHC & ~in_idle_q, OCR_VOLT};
        dec_len = 3'd5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 3'd0;
      len_q       <= 3'd1;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      resp_q      <= 40'hFF_FFFF_FFFF;
      in_idle_q   <= 1'b1;
      app_q       <= 1'b0;
      acmd_q      <= 8'd0;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'd0;
      ready_q     <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      ready_q     <= ~in_idle_q;
      if (cs_s) begin
        cnt_q <= 3'd0;
      end else if (done) begin
        unique case (state_q)
          ST_RX_WAIT: begin
            if (rx_byte[7:6] == 2'b01) begin
              idx_q <= rx_byte[5:0];
              cnt_q <= 3'd1;
            end
          end
          ST_CMD: begin
            if (cnt_q == 3'd5) begin
              cmd_valid_q <= 1'b1;
              cmd_index_q <= idx_q;
              cmd_arg_q   <= arg_q;
              resp_q      <= dec_resp;
              len_q       <= dec_len;
              in_idle_q   <= idle_d;
              app_q       <= app_d;
              acmd_q      <= acmd_d;
              cnt_q       <= 3'd0;
            end else begin
              arg_q <= {arg_q[23:0], rx_byte};
              cnt_q <= cnt_q + 3'd1;
            end
          end
          ST_NCR: cnt_q <= ncr_last ? 3'd0 : cnt_q + 3'd1;
          ST_RESP: begin
            resp_q <= {resp_q[31:0], 8'hFF};
            cnt_q  <= resp_last ? 3'd0 : cnt_q + 3'd1;
          end
          default: cnt_q <= 3'd0;
        endcase
      end
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;
  assign cmd_arg    = cmd_arg_q;
  assign card_ready = ready_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: SPI host model with a byte scoreboard,
// one default card and one SD1/SDSC card.
module tb_sd_spi_responder;

  typedef logic [7:0] b_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b1;
  logic        cs0 = 1'b1;
  logic        cs1 = 1'b1;
  logic        miso0, miso1, cv0, cv1, rdy0, rdy1;
  logic [5:0]  idx0, idx1;
  logic [31:0] arg0, arg1;

  int checks = 0;
  int failures = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;

  b_t txq[$];
  b_t rxq[$];
  b_t expq[$];

  always #5 clock = ~clock;

  sd_spi_responder dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .spi_cs     (cs0),
    .spi_sclk   (sclk),
    .spi_mosi   (mosi),
    .spi_miso   (miso0),
    .cmd_valid  (cv0),
    .cmd_index  (idx0),
    .cmd_arg    (arg0),
    .card_ready (rdy0)
  );

  sd_spi_responder #(
    .SD_V2 (1'b0),
    .SDHC  (1'b0)
  ) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .spi_cs     (cs1),
    .spi_sclk   (sclk),
    .spi_mosi   (mosi),
    .spi_miso   (miso1),
    .cmd_valid  (cv1),
    .cmd_index  (idx1),
    .cmd_arg    (arg1),
    .card_ready (rdy1)
  );

  always @(posedge clock) begin
    if (cv0) vcnt0 <= vcnt0 + 1;
    if (cv1) vcnt1 <= vcnt1 + 1;
  end

  task automatic xfer(input int dev, input b_t tx, output b_t rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #50;
      sclk = 1'b1;
      rx[i] = (dev == 0) ? miso0 : miso1;
      #50;
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int dev);
    b_t r;
    if (dev == 0) cs0 = 1'b0;
    else          cs1 = 1'b0;
    #100;
    while (txq.size() > 0) begin
      xfer(dev, txq.pop_front(), r);
      rxq.push_back(r);
    end
    #100;
    cs0 = 1'b1;
    cs1 = 1'b1;
    mosi = 1'b1;
    #200;
  endtask

  // command bytes read back FFh, plus the NCR filler; n response reads
  task automatic push_cmd(input logic [47:0] c, input int n, input b_t fill);
    for (int i = 5; i >= 0; i--) begin
      txq.push_back(c[i*8 +: 8]);
      expq.push_back(8'hFF);
    end
    expq.push_back(8'hFF);
    for (int i = 0; i <= n; i++) txq.push_back(fill);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #100;
    checks++;
    if (miso0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_miso got=%b want=1", miso0);
    end
    checks++;
    if (cv0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_cmd_valid got=%b want=0", cv0);
    end
    checks++;
    if (idx0 !== 6'd0) begin
      failures++;
      $display("FAIL reset_cmd_index got=%0d want=0", idx0);
    end
    checks++;
    if (arg0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_cmd_arg got=%08h want=0", arg0);
    end
    checks++;
    if (rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_card_ready got=%b want=0", rdy0);
    end
    reset_n = 1'b1;
    #100;
  endtask

  task automatic test_cmd0();
    b_t got, want;
    int v, n;
    v = vcnt0;
    n = 0;
    push_cmd(48'h40_00_00_00_00_95, 1, 8'hFF);
    expq.push_back(8'h01);
    run_frame(0);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL cmd0 byte%0d got=%02h want=%02h", n, got, want);
      end
      n++;
    end
    checks++;
    if (vcnt0 !== v + 1) begin
      failures++;
      $display("FAIL cmd0_valid got=%0d want=%0d", vcnt0 - v, 1);
    end
    checks++;
    if (idx0 !== 6'd0 || rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL cmd0_state got=%0d/%b want=0/0", idx0, rdy0);
    end
  endtask

  task automatic test_cmd8();
    b_t got, want;
    int n;
    n = 0;
    push_cmd(48'h48_00_00_01_AA_87, 5, 8'hFF);
    foreach (txq[i]) if (i < 0) txq.delete();
    expq.push_back(8'h01);
    expq.push_back(8'h00);
    expq.push_back(8'h00);
    expq.push_back(8'h01);
    expq.push_back(8'hAA);
    run_frame(0);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL cmd8 byte%0d got=%02h want=%02h", n, got, want);
      end
      n++;
    end
    checks++;
    if (arg0 !== 32'h0000_01AA || idx0 !== 6'd8) begin
      failures++;
      $display("FAIL cmd8_latch got=%0d/%08h want=8/000001aa", idx0, arg0);
    end
  endtask

  task automatic test_acmd41(input int dev);
    b_t got, want;
    logic rdy;
    for (int k = 0; k < 3; k++) begin
      push_cmd(48'h77_00_00_00_00_65, 1, 8'hFF);
      expq.push_back(8'h01);
      push_cmd(48'h69_40_00_00_00_77, 1, 8'hFF);
      expq.push_back((k < 2) ? 8'h01 : 8'h00);
      run_frame(dev);
      while (rxq.size() > 0) begin
        got = rxq.pop_front();
        want = expq.pop_front();
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL acmd41 dev%0d loop%0d got=%02h want=%02h",
                   dev, k, got, want);
        end
      end
      rdy = (dev == 0) ? rdy0 : rdy1;
      checks++;
      if (rdy !== (k == 2)) begin
        failures++;
        $display("FAIL acmd41_ready dev%0d loop%0d got=%b want=%b",
                 dev, k, rdy, (k == 2));
      end
    end
  endtask

  task automatic test_cmd58_ready();
    b_t got, want;
    push_cmd(48'h7A_00_00_00_00_FD, 5, 8'hFF);
    expq.push_back(8'h00);
    expq.push_back(8'hC0);
    expq.push_back(8'hFF);
    expq.push_back(8'h80);
    expq.push_back(8'h00);
    run_frame(0);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL cmd58_sdhc got=%02h want=%02h", got, want);
      end
    end
  endtask

  task automatic test_illegal();
    b_t got, want;
    push_cmd(48'h40_00_00_00_00_95, 1, 8'hFF);
    expq.push_back(8'h01);
    push_cmd(48'h51_00_00_00_00_55, 1, 8'hFF);
    expq.push_back(8'h05);
    push_cmd(48'h77_00_00_00_00_65, 1, 8'hFF);
    expq.push_back(8'h01);
    push_cmd(48'h40_00_00_00_00_95, 1, 8'hFF);
    expq.push_back(8'h01);
    push_cmd(48'h69_40_00_00_00_77, 1, 8'hFF);
    expq.push_back(8'h05);
    run_frame(0);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL illegal got=%02h want=%02h", got, want);
      end
    end
    checks++;
    if (rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL illegal_ready got=%b want=0", rdy0);
    end
  endtask

  task automatic test_abort();
    b_t got, want;
    int v;
    v = vcnt0;
    txq.push_back(8'h40);
    txq.push_back(8'h00);
    txq.push_back(8'h00);
    repeat (3) expq.push_back(8'hFF);
    run_frame(0);
    push_cmd(48'h48_00_00_01_AA_87, 1, 8'hFF);
    expq.push_back(8'h01);
    run_frame(0);
    push_cmd(48'h40_00_00_00_00_95, 1, 8'hFF);
    expq.push_back(8'h01);
    run_frame(0);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL abort got=%02h want=%02h", got, want);
      end
    end
    checks++;
    if (vcnt0 !== v + 2 || idx0 !== 6'd0) begin
      failures++;
      $display("FAIL abort_valid got=%0d/%0d want=2/0", vcnt0 - v, idx0);
    end
  endtask

  task automatic test_back_to_back();
    b_t got, want;
    txq.push_back(8'hFF);
    txq.push_back(8'hFF);
    expq.push_back(8'hFF);
    expq.push_back(8'hFF);
    push_cmd(48'h40_00_00_00_00_95, 1, 8'h40);
    expq.push_back(8'h01);
    push_cmd(48'h48_00_00_02_5A_01, 5, 8'hFF);
    expq.push_back(8'h01);
    expq.push_back(8'h00);
    expq.push_back(8'h00);
    expq.push_back(8'h02);
    expq.push_back(8'h5A);
    push_cmd(48'h7A_00_00_00_00_FD, 5, 8'hFF);
    expq.push_back(8'h01);
    expq.push_back(8'h00);
    expq.push_back(8'hFF);
    expq.push_back(8'h80);
    expq.push_back(8'h00);
    run_frame(0);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL b2b got=%02h want=%02h", got, want);
      end
    end
    checks++;
    if (idx0 !== 6'd58 || arg0 !== 32'd0) begin
      failures++;
      $display("FAIL b2b_latch got=%0d/%08h want=58/0", idx0, arg0);
    end
  endtask

  task automatic test_sd1();
    b_t got, want;
    push_cmd(48'h40_00_00_00_00_95, 1, 8'hFF);
    expq.push_back(8'h01);
    push_cmd(48'h48_00_00_01_AA_87, 1, 8'hFF);
    expq.push_back(8'h05);
    run_frame(1);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL sd1_cmd8 got=%02h want=%02h", got, want);
      end
    end
    test_acmd41(1);
    push_cmd(48'h7A_00_00_00_00_FD, 5, 8'hFF);
    expq.push_back(8'h00);
    expq.push_back(8'h80);
    expq.push_back(8'hFF);
    expq.push_back(8'h80);
    expq.push_back(8'h00);
    push_cmd(48'h77_00_00_00_00_65, 1, 8'hFF);
    expq.push_back(8'h00);
    push_cmd(48'h69_40_00_00_00_77, 1, 8'hFF);
    expq.push_back(8'h00);
    run_frame(1);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL sd1_ready got=%02h want=%02h", got, want);
      end
    end
  endtask

  task automatic test_reset_midway();
    b_t got, want;
    reset_n = 1'b0;
    #100;
    checks++;
    if (rdy1 !== 1'b0 || idx1 !== 6'd0 || arg1 !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%0d/%08h want=0/0/0", rdy1, idx1, arg1);
    end
    reset_n = 1'b1;
    #100;
    push_cmd(48'h7A_00_00_00_00_FD, 5, 8'hFF);
    expq.push_back(8'h01);
    expq.push_back(8'h00);
    expq.push_back(8'hFF);
    expq.push_back(8'h80);
    expq.push_back(8'h00);
    run_frame(1);
    while (rxq.size() > 0) begin
      got = rxq.pop_front();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL rst_mid_cmd58 got=%02h want=%02h", got, want);
      end
    end
  endtask

  initial begin
    #50;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_acmd41(0);
    test_cmd58_ready();
    test_illegal();
    test_abort();
    test_back_to_back();
    test_sd1();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
